// File: rtl/rvc_asap_5pl_d_mem_arb_if.sv
// Bus bundle for the data-memory arbiter: two requester ports, the single memory port
// and the performance counters.
//   slave  : arbiter side (takes requests and mem_q_i, drives grants, responses, mem_*)
//   master : environment side (requesters, memory model, counter observer)
interface rvc_asap_5pl_d_mem_arb_if #(
  parameter int unsigned CNT_W = 16
);
  // Port 0: core load/store stage
  logic             p0_valid_i;
  logic             p0_ready_o;
  logic [31:0]      p0_addr_i;
  logic [31:0]      p0_wdata_i;
  logic [3:0]       p0_byteen_i;
  logic             p0_wren_i;
  logic             p0_rsp_valid_o;
  logic [31:0]      p0_rdata_o;
  // Port 1: external requester (debug / DMA)
  logic             p1_valid_i;
  logic             p1_ready_o;
  logic [31:0]      p1_addr_i;
  logic [31:0]      p1_wdata_i;
  logic [3:0]       p1_byteen_i;
  logic             p1_wren_i;
  logic             p1_rsp_valid_o;
  logic [31:0]      p1_rdata_o;
  // Memory port
  logic [31:0]      mem_data_o;
  logic [31:0]      mem_addr_o;
  logic [3:0]       mem_byteen_o;
  logic             mem_wren_o;
  logic             mem_rden_o;
  logic [31:0]      mem_q_i;
  // Performance counters
  logic [CNT_W-1:0] p0_grant_cnt_o;
  logic [CNT_W-1:0] p1_grant_cnt_o;
  logic [CNT_W-1:0] conflict_cnt_o;

  modport slave (
    input  p0_valid_i, p0_addr_i, p0_wdata_i, p0_byteen_i, p0_wren_i,
    input  p1_valid_i, p1_addr_i, p1_wdata_i, p1_byteen_i, p1_wren_i,
    input  mem_q_i,
    output p0_ready_o, p0_rsp_valid_o, p0_rdata_o,
    output p1_ready_o, p1_rsp_valid_o, p1_rdata_o,
    output mem_data_o, mem_addr_o, mem_byteen_o, mem_wren_o, mem_rden_o,
    output p0_grant_cnt_o, p1_grant_cnt_o, conflict_cnt_o
  );

  modport master (
    output p0_valid_i, p0_addr_i, p0_wdata_i, p0_byteen_i, p0_wren_i,
    output p1_valid_i, p1_addr_i, p1_wdata_i, p1_byteen_i, p1_wren_i,
    output mem_q_i,
    input  p0_ready_o, p0_rsp_valid_o, p0_rdata_o,
    input  p1_ready_o, p1_rsp_valid_o, p1_rdata_o,
    input  mem_data_o, mem_addr_o, mem_byteen_o, mem_wren_o, mem_rden_o,
    input  p0_grant_cnt_o, p1_grant_cnt_o, conflict_cnt_o
  );
endinterface

// File: rtl/rvc_asap_5pl_d_mem_arb.sv
// Two-requester arbiter/sequencer for the single data-memory port of the 5-stage core.
// Port 0 (load/store stage) has default priority; port 1 wins when port 0 is idle or
// after STARVE_LIMIT consecutive denied cycles. Grants are combinational, reads return
// one cycle later and are routed back to the issuing port.
// Ports:
//   clock : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : requester ports, memory port and performance counters (slave modport)
module rvc_asap_5pl_d_mem_arb #(
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned CNT_W        = 16
) (
  input logic                     clock,
  input logic                     rst_n,
  rvc_asap_5pl_d_mem_arb_if.slave bus
);

  localparam logic [7:0] Limit = 8'(STARVE_LIMIT);

  logic [7:0]       starve_q, starve_d;
  logic             rd_pend_q, rd_pend_d;
  logic             rd_src_q, rd_src_d;
  logic [CNT_W-1:0] p0_cnt_q, p0_cnt_d;
  logic [CNT_W-1:0] p1_cnt_q, p1_cnt_d;
  logic [CNT_W-1:0] conflict_q, conflict_d;

  logic p1_wins, gnt0, gnt1, rd_grant, both_valid;

  // Grants are masked by rst_n so nothing reaches the memory while in reset.
  assign p1_wins    = bus.p1_valid_i && (!bus.p0_valid_i || (starve_q == Limit));
  assign gnt1       = rst_n && p1_wins;
  assign gnt0       = rst_n && bus.p0_valid_i && !p1_wins;
  assign rd_grant   = (gnt0 && !bus.p0_wren_i) || (gnt1 && !bus.p1_wren_i);
  assign both_valid = bus.p0_valid_i && bus.p1_valid_i;

  assign bus.p0_ready_o = gnt0;
  assign bus.p1_ready_o = gnt1;

  // Memory port mux
  always_comb begin
    bus.mem_data_o   = '0;
    bus.mem_addr_o   = '0;
    bus.mem_byteen_o = '0;
    bus.mem_wren_o   = 1'b0;
    bus.mem_rden_o   = 1'b0;
    if (gnt0) begin
      bus.mem_data_o   = bus.p0_wdata_i;
      bus.mem_addr_o   = bus.p0_addr_i;
      bus.mem_byteen_o = bus.p0_byteen_i;
      bus.mem_wren_o   = bus.p0_wren_i;
      bus.mem_rden_o   = !bus.p0_wren_i;
    end else if (gnt1) begin
      bus.mem_data_o   = bus.p1_wdata_i;
      bus.mem_addr_o   = bus.p1_addr_i;
      bus.mem_byteen_o = bus.p1_byteen_i;
      bus.mem_wren_o   = bus.p1_wren_i;
      bus.mem_rden_o   = !bus.p1_wren_i;
    end
  end

  // Read responses: mem_q_i is steered to whichever port issued last cycle's read.
  always_comb begin
    bus.p0_rsp_valid_o = rst_n && rd_pend_q && !rd_src_q;
    bus.p1_rsp_valid_o = rst_n && rd_pend_q && rd_src_q;
    bus.p0_rdata_o     = bus.p0_rsp_valid_o ? bus.mem_q_i : 32'h0;
    bus.p1_rdata_o     = bus.p1_rsp_valid_o ? bus.mem_q_i : 32'h0;
  end

  // Next-state
  always_comb begin
    starve_d   = starve_q;
    rd_pend_d  = rd_grant;
    rd_src_d   = rd_grant ? gnt1 : rd_src_q;
    p0_cnt_d   = p0_cnt_q;
    p1_cnt_d   = p1_cnt_q;
    conflict_d = conflict_q;

    if (!bus.p1_valid_i || gnt1) begin
      starve_d = 8'd0;
    end else if (starve_q != Limit) begin
      starve_d = starve_q + 8'd1;
    end

    if (gnt0) p0_cnt_d = p0_cnt_q + CNT_W'(1);
    if (gnt1) p1_cnt_d = p1_cnt_q + CNT_W'(1);
    if (both_valid && (conflict_q != '1)) conflict_d = conflict_q + CNT_W'(1);
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      starve_q   <= 8'd0;
      rd_pend_q  <= 1'b0;
      rd_src_q   <= 1'b0;
      p0_cnt_q   <= '0;
      p1_cnt_q   <= '0;
      conflict_q <= '0;
    end else begin
      starve_q   <= starve_d;
      rd_pend_q  <= rd_pend_d;
      rd_src_q   <= rd_src_d;
      p0_cnt_q   <= p0_cnt_d;
      p1_cnt_q   <= p1_cnt_d;
      conflict_q <= conflict_d;
    end
  end

  assign bus.p0_grant_cnt_o = p0_cnt_q;
  assign bus.p1_grant_cnt_o = p1_cnt_q;
  assign bus.conflict_cnt_o = conflict_q;

endmodule

// File: doc/rvc_asap_5pl_d_mem_arb.md
# rvc_asap_5pl_d_mem_arb

Two-requester arbiter and sequencer for the single port of the 5-stage core's data memory. It shares the port between the core load/store stage (port 0) and an external requester such as a debug or DMA master (port 1). It drives the memory's write/read/byte-enable controls and tracks the one-cycle synchronous read latency, so each read response is routed back to the port that issued it. Starvation of port 1 is bounded by a wait counter; per-port grant and conflict counters are exported for performance monitoring.

## Interface
- STARVE_LIMIT, 8: consecutive denied cycles after which port 1 outranks port 0 (legal 1..255)
- CNT_W, 16: width of the performance counters
- clock  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- p0_valid_i / p1_valid_i  in  1  request valid
- p0_ready_o / p1_ready_o  out  1  grant; transfer occurs when valid && ready
- p0_addr_i / p1_addr_i  in  32  byte address
- p0_wdata_i / p1_wdata_i  in  32  store data
- p0_byteen_i / p1_byteen_i  in  4  byte lanes
- p0_wren_i / p1_wren_i  in  1  1 = store, 0 = load
- p0_rsp_valid_o / p1_rsp_valid_o  out  1  load data valid
- p0_rdata_o / p1_rdata_o  out  32  load data
- mem_data_o  out  32  to memory data_a
- mem_addr_o  out  32  to memory address_a
- mem_byteen_o  out  4  to memory byteena_a
- mem_wren_o  out  1  to memory wren_a
- mem_rden_o  out  1  to memory rden_a
- mem_q_i  in  32  from memory q_a; valid the cycle after a read
- p0_grant_cnt_o / p1_grant_cnt_o  out  CNT_W  granted transfers, wrapping
- conflict_cnt_o  out  CNT_W  cycles with both valids high, saturating at all-ones

## Operation
- Grant is combinational, with at most one grant per cycle. Default priority is port 0.
- Port 1 wins if starve_cnt == STARVE_LIMIT, or if p0_valid_i is low.
- starve_cnt (8-bit) behaviour:
  - +1 each cycle p1_valid_i && !p1_ready_o, saturating at STARVE_LIMIT.
  - Cleared on a port 1 grant or whenever p1_valid_i is low.
- Memory port mux: granted port's addr/wdata/byteen drive mem_*.
  - mem_wren_o = grant && wren.
  - mem_rden_o = grant && !wren.
  - No grant: all mem_* outputs are 0.
- Read tracking: registers rd_pend (1 bit) and rd_src (0/1), loaded on every read grant. The next cycle asserts p<rd_src>_rsp_valid_o for exactly one cycle, with p<rd_src>_rdata_o = mem_q_i (lanes already masked by the memory).
- Responses are combinational from mem_q_i and the registered rd_pend/rd_src. The non-selected port's rdata is 0.
- Writes produce no response; the handshake is the completion.
- Back-to-back reads, including alternating ports, are fully pipelined: one response per cycle.
- Counters:
  - pN_grant_cnt increments on every pN handshake and wraps.
  - conflict_cnt increments when p0_valid_i && p1_valid_i, saturating.

## Timing
- Reset (rst_n low, asynchronous) clears starve_cnt, rd_pend, rd_src and all counters to 0.
- While rst_n is low, all ready, rsp_valid and mem_* outputs are 0.
- A read pending when reset asserts is dropped; no response follows reset release.
- Request to grant: 0 cycles. Read grant to rsp_valid: 1 cycle. Write grant to memory update: the same rising edge.
- Requesters must hold valid and request fields stable until granted. The arbiter never withdraws a grant within a cycle.
- Starvation bound: port 1 is granted no later than STARVE_LIMIT+1 cycles after raising valid.
- When the limit is reached, port 0 is held off for exactly that cycle; starve_cnt returns to 0 after the port 1 grant.
- Simultaneous events:
  - A response for one port and a new grant (either port) occur in the same cycle independently.
  - Saturation and the counter increment are evaluated on the pre-edge value.

## Test plan
- Reset: hold rst_n=0 with both valids high -> readys 0, mem_wren_o=mem_rden_o=0, all counters 0; release -> p0 granted first cycle.
- Write/read p0: store 0xDEADBEEF, byteen 4'hF, addr 0x1000, then load addr 0x1000 -> p0_rsp_valid_o one cycle after the load grant, p0_rdata_o=0xDEADBEEF; p1_rsp_valid_o stays 0.
- Partial lanes: p1 load addr 0x1000, byteen 4'b0011 -> p1_rdata_o=0x0000BEEF, response routed to p1 only.
- Starvation, STARVE_LIMIT=8: p0 and p1 valid continuously -> p1 granted on the 9th cycle, p0 granted on all others; conflict_cnt increments every cycle.
- Alternating reads p0,p1,p0 on consecutive cycles -> responses on consecutive cycles to p0,p1,p0 with the correct data.
- Reset mid-read: assert rst_n low the cycle after a p1 read grant -> no p1_rsp_valid_o; grant counters read 0 after release.
